oled_spi_rx: RTL and testbench

Receive-side counterpart of the OLED SPI display driver: a 4-wire SPI (CS#, SCLK, D/C, MOSI) byte receiver plus SSD1331 command-framing decoder. It runs in the `clk_in` domain and oversamples the driver's pins. It is used as a loopback checker and a display-side stand-in, so a captured command/data stream can be compared against the intended sequence. Decoded bytes leave through a small FIFO with a valid/ready handshake.

---
 rtl/oled_spi_rx.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_oled_spi_rx.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_spi_rx.sv
// ----------------------------------------------------------------------------
// oled_spi_rx
//
// Display-side receiver for the 4-wire OLED SPI link (CS#, SCLK, D/C, MOSI).
// The SPI pins are oversampled in the clk_in domain. Each completed byte is
// tagged with its D/C level. When the command decoder is built in, command
// bytes are also classified as opcode or argument. The tagged byte is then
// queued in a small FIFO with a valid/ready handshake.
//
// Build option:
//   OLED_RX_CMD_DECODE_EN  - when defined, the SSD1331 command parser and
//                            opcode table are present. When undefined,
//                            rx_is_arg/rx_arg_idx read 0 and cmd_err is 0.
//
// Parameters:
//   FIFO_DEPTH   - output FIFO entries (power of two, >= 2)
//   SYNC_STAGES  - synchronizer flops on each SPI input (>= 2)
//
// Ports:
//   clk_in        system clock
//   rst_n_in      asynchronous active-low reset
//   oled_cs_n_in  SPI chip select, active-low
//   oled_clk_in   SPI clock, idle low
//   oled_dc_in    0 = command byte, 1 = data byte
//   oled_data_in  MOSI, MSB first
//   rx_data       FIFO head byte
//   rx_dc         D/C level captured with bit 0 of the head byte
//   rx_is_arg     head byte is a command argument
//   rx_arg_idx    0 for an opcode, 1..N for arguments
//   rx_valid      FIFO head valid
//   rx_ready      consumer accepts head when rx_valid & rx_ready
//   overflow      sticky: a byte was dropped on a full FIFO
//   frag_err      pulse: CS# rose with 1..7 bits shifted in
//   cmd_err       pulse: unknown opcode, or data while arguments pending
// ----------------------------------------------------------------------------
module oled_spi_rx #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       oled_cs_n_in,
    input  logic       oled_clk_in,
    input  logic       oled_dc_in,
    input  logic       oled_data_in,
    output logic [7:0] rx_data,
    output logic       rx_dc,
    output logic       rx_is_arg,
    output logic [3:0] rx_arg_idx,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       overflow,
    output logic       frag_err,
    output logic       cmd_err
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
`ifdef OLED_RX_CMD_DECODE_EN
    localparam int EW = 14;   // {data, dc, is_arg, arg_idx}
`else
    localparam int EW = 9;    // {data, dc}
`endif

    // ---- Stage p0: input synchronizers and SCLK edge detect ----
    logic [SYNC_STAGES-1:0] cs_sync_p0;
    logic [SYNC_STAGES-1:0] sclk_sync_p0;
    logic [SYNC_STAGES-1:0] dc_sync_p0;
    logic [SYNC_STAGES-1:0] mosi_sync_p0;
    logic                   sclk_d_p0;
    logic                   cs_s;
    logic                   sclk_s;
    logic                   dc_s;
    logic                   mosi_s;
    logic                   sclk_rise;

    // Control inputs come out of reset at their idle levels (CS# high,
    // SCLK low), so no false edge or spurious fragment follows reset.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cs_sync_p0   <= '1;
            sclk_sync_p0 <= '0;
            sclk_d_p0    <= 1'b0;
        end else begin
            cs_sync_p0   <= {cs_sync_p0[SYNC_STAGES-2:0], oled_cs_n_in};
            sclk_sync_p0 <= {sclk_sync_p0[SYNC_STAGES-2:0], oled_clk_in};
            sclk_d_p0    <= sclk_s;
        end
    end

    always_ff @(posedge clk_in) begin
        dc_sync_p0   <= {dc_sync_p0[SYNC_STAGES-2:0], oled_dc_in};
        mosi_sync_p0 <= {mosi_sync_p0[SYNC_STAGES-2:0], oled_data_in};
    end

    assign cs_s      = cs_sync_p0[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_p0[SYNC_STAGES-1];
    assign dc_s      = dc_sync_p0[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_p0[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d_p0;

    // ---- Stage p1: shift register and byte completion ----
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic [7:0] rx_byte_p1;
    logic       dc_p1;
    logic       vld_p1;
    logic       frag_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bit_cnt <= 3'd0;
            vld_p1  <= 1'b0;
            frag_q  <= 1'b0;
        end else if (cs_s) begin
            bit_cnt <= 3'd0;
            vld_p1  <= 1'b0;
            frag_q  <= (bit_cnt != 3'd0);
        end else begin
            frag_q  <= 1'b0;
            vld_p1  <= sclk_rise && (bit_cnt == 3'd7);
            if (sclk_rise) begin
                bit_cnt <= bit_cnt + 3'd1;   // wraps to 0 after the 8th bit
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (cs_s) begin
            shreg <= 8'h00;
        end else if (sclk_rise) begin
            shreg <= {shreg[6:0], mosi_s};
            if (bit_cnt == 3'd7) begin
                rx_byte_p1 <= {shreg[6:0], mosi_s};
                dc_p1      <= dc_s;
            end
        end
    end

    assign frag_err = frag_q;

    // ---- Stage p2: command parser and FIFO push ----
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic [EW-1:0] entry_d;
    logic [EW-1:0] head;
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic          ovf_q;

`ifdef OLED_RX_CMD_DECODE_EN
    typedef enum logic {IDLE_P, ARGS} pstate_t;

    pstate_t    state_q;
    pstate_t    state_d;
    logic [3:0] args_left_q;
    logic [3:0] args_left_d;
    logic [3:0] arg_pos_q;
    logic [3:0] arg_pos_d;
    logic       is_arg_d;
    logic [3:0] arg_idx_d;
    logic       cmd_err_d;
    logic       cmd_err_q;
    logic [4:0] op_info;

    // Returns {known, argument_count} for an SSD1331 opcode.
    function automatic logic [4:0] op_args(input logic [7:0] op);
        logic [4:0] r;
        case (op)
            8'h15, 8'h75:                                   r = {1'b1, 4'd2};
            8'h81, 8'h82, 8'h83, 8'h87, 8'h8A, 8'h8B, 8'h8C,
            8'hA0, 8'hA1, 8'hA2, 8'hA8, 8'hAD, 8'hB0, 8'hB1,
            8'hB3, 8'hBB, 8'hBE, 8'h26, 8'hFD:              r = {1'b1, 4'd1};
            8'h25:                                          r = {1'b1, 4'd4};
            8'h21:                                          r = {1'b1, 4'd7};
            8'h22:                                          r = {1'b1, 4'd10};
            8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hAE, 8'hAF, 8'hE3: r = {1'b1, 4'd0};
            default:                                        r = {1'b0, 4'd0};
        endcase
        return r;
    endfunction

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= IDLE_P;
            args_left_q <= 4'd0;
            arg_pos_q   <= 4'd0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            args_left_q <= args_left_d;
            arg_pos_q   <= arg_pos_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    // The parser advances on every completed byte, whether or not the
    // FIFO has room for it.
    always_comb begin
        state_d     = state_q;
        args_left_d = args_left_q;
        arg_pos_d   = arg_pos_q;
        is_arg_d    = 1'b0;
        arg_idx_d   = 4'd0;
        cmd_err_d   = 1'b0;
        op_info     = op_args(rx_byte_p1);
        if (vld_p1) begin
            if (dc_p1) begin
                if (state_q == ARGS) begin
                    cmd_err_d   = 1'b1;
                    args_left_d = 4'd0;
                    state_d     = IDLE_P;
                end
            end else if (state_q == IDLE_P) begin
                cmd_err_d   = ~op_info[4];
                args_left_d = op_info[3:0];
                arg_pos_d   = 4'd1;
                if (op_info[3:0] != 4'd0) begin
                    state_d = ARGS;
                end
            end else begin
                is_arg_d    = 1'b1;
                arg_idx_d   = arg_pos_q;
                args_left_d = args_left_q - 4'd1;
                arg_pos_d   = arg_pos_q + 4'd1;
                if (args_left_q == 4'd1) begin
                    state_d = IDLE_P;
                end
            end
        end
    end

    assign entry_d    = {rx_byte_p1, dc_p1, is_arg_d, arg_idx_d};
    assign cmd_err    = cmd_err_q;
    assign rx_is_arg  = ~fifo_empty & head[4];
    assign rx_arg_idx = fifo_empty ? 4'd0 : head[3:0];
`else
    assign entry_d    = {rx_byte_p1, dc_p1};
    assign cmd_err    = 1'b0;
    assign rx_is_arg  = 1'b0;
    assign rx_arg_idx = 4'd0;
`endif

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = ~fifo_empty & rx_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push       = vld_p1 & (~fifo_full | pop);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            if (vld_p1 && fifo_full && !pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= entry_d;
        end
    end

    // Head fields are forced to zero while empty so the outputs show their
    // reset values without resetting the storage array.
    assign head     = mem[rd_ptr[AW-1:0]];
    assign rx_valid = ~fifo_empty;
    assign rx_data  = fifo_empty ? 8'h00 : head[EW-1 -: 8];
    assign rx_dc    = ~fifo_empty & head[EW-9];
    assign overflow = ovf_q;

endmodule

// File: tb/tb_oled_spi_rx.sv
// ----------------------------------------------------------------------------
// tb_oled_spi_rx
//
// Self-checking bench for oled_spi_rx. A transaction-level model holds the
// bytes the FIFO must deliver. It tags command bytes from a count of pending
// arguments and predicts error pulses and overflow. A monitor compares every
// accepted head entry against the model, and directed scenarios pin the model
// with hand-computed values. Honours OLED_RX_CMD_DECODE_EN.
// ----------------------------------------------------------------------------
module tb_oled_spi_rx;

    localparam int FIFO_DEPTH  = 4;
    localparam int SYNC_STAGES = 2;
    localparam int HALF_SCLK   = 4;   // SCLK = clk_in / 8

    logic       clk_in       = 1'b0;
    logic       rst_n_in     = 1'b0;
    logic       oled_cs_n_in = 1'b1;
    logic       oled_clk_in  = 1'b0;
    logic       oled_dc_in   = 1'b0;
    logic       oled_data_in = 1'b0;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_dc;
    logic       rx_is_arg;
    logic [3:0] rx_arg_idx;
    logic       rx_valid;
    logic       overflow;
    logic       frag_err;
    logic       cmd_err;

    oled_spi_rx #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .oled_cs_n_in (oled_cs_n_in),
        .oled_clk_in  (oled_clk_in),
        .oled_dc_in   (oled_dc_in),
        .oled_data_in (oled_data_in),
        .rx_data      (rx_data),
        .rx_dc        (rx_dc),
        .rx_is_arg    (rx_is_arg),
        .rx_arg_idx   (rx_arg_idx),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .overflow     (overflow),
        .frag_err     (frag_err),
        .cmd_err      (cmd_err)
    );

    always #20 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_edge_cyc = 0;
    int lat = -1;
    bit prev_valid = 1'b0;
    int exp_cmd = 0, cmd_seen = 0;
    int exp_frag = 0, frag_seen = 0;
    bit exp_ovf = 1'b0;
    int m_left = 0, m_pos = 0;
    int argc_tbl [256];
    logic [13:0] q [$];
    logic [7:0] last_data = 8'h00;
    logic       last_dc = 1'b0, last_is_arg = 1'b0;
    logic [3:0] last_idx = 4'd0;
    bit rnd_mode = 1'b0;
    bit ready_force = 1'b0;
    bit decode_en;

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(posedge clk_in) begin
        #1;
        rx_ready = rnd_mode ? ($urandom_range(0, 3) != 0) : ready_force;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // Model: what the receiver must report for one completed byte.
    task automatic model_byte(input logic [7:0] b, input logic dc);
        logic       is_arg = 1'b0;
        logic [3:0] idx = 4'd0;
        if (decode_en) begin
            if (dc) begin
                if (m_left > 0) exp_cmd++;
                m_left = 0;
            end else if (m_left == 0) begin
                m_left = argc_tbl[b];
                if (m_left < 0) begin
                    exp_cmd++;
                    m_left = 0;
                end
                m_pos = 0;
            end else begin
                m_pos++;
                m_left--;
                is_arg = 1'b1;
                idx    = 4'(m_pos);
            end
        end
        if (q.size() >= FIFO_DEPTH) exp_ovf = 1'b1;
        else q.push_back({b, dc, is_arg, idx});
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dc, input bit keep_cs);
        if (oled_cs_n_in) begin
            oled_cs_n_in = 1'b0;
            wait_cyc(HALF_SCLK);
        end
        oled_dc_in = dc;
        for (int i = 7; i >= 0; i--) begin
            oled_data_in = b[i];
            wait_cyc(HALF_SCLK);
            oled_clk_in = 1'b1;
            if (i == 0) begin
                last_edge_cyc = cyc;
                model_byte(b, dc);
            end
            wait_cyc(HALF_SCLK);
            oled_clk_in = 1'b0;
        end
        wait_cyc(HALF_SCLK);
        if (!keep_cs) begin
            oled_cs_n_in = 1'b1;
            wait_cyc(6);
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits);
        oled_cs_n_in = 1'b0;
        wait_cyc(HALF_SCLK);
        for (int i = 7; i > 7 - nbits; i--) begin
            oled_data_in = b[i];
            wait_cyc(HALF_SCLK);
            oled_clk_in = 1'b1;
            wait_cyc(HALF_SCLK);
            oled_clk_in = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && q.size() > 0; i++) wait_cyc(1);
        chk("drain_remaining", q.size(), 0);
        wait_cyc(3);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, rx_valid, 0);
        chk({tag, "_data"}, rx_data, 0);
        chk({tag, "_dc"}, rx_dc, 0);
        chk({tag, "_is_arg"}, rx_is_arg, 0);
        chk({tag, "_arg_idx"}, rx_arg_idx, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_frag_err"}, frag_err, 0);
        chk({tag, "_cmd_err"}, cmd_err, 0);
    endtask

    // Monitor: every accepted head entry must be the model's next entry.
    always @(negedge clk_in) begin
        if (!rst_n_in) begin
            prev_valid = 1'b0;
        end else begin
            if (frag_err) frag_seen++;
            if (cmd_err)  cmd_seen++;
            if (rx_valid && !prev_valid) lat = cyc - last_edge_cyc;
            prev_valid = rx_valid;
            if (rx_valid && rx_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_entry: got %0h, expected no entry", rx_data);
                end else begin
                    chk("entry", {rx_data, rx_dc, rx_is_arg, rx_arg_idx}, q.pop_front());
                    last_data   = rx_data;
                    last_dc     = rx_dc;
                    last_is_arg = rx_is_arg;
                    last_idx    = rx_arg_idx;
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ops [26] = '{8'h15, 8'h75, 8'h81, 8'h82, 8'h83, 8'h87, 8'h8A,
                                 8'h8B, 8'h8C, 8'hA0, 8'hA1, 8'hA2, 8'hA8, 8'hAD,
                                 8'hB0, 8'hB1, 8'hB3, 8'hBB, 8'hBE, 8'h26, 8'hFD,
                                 8'h25, 8'h21, 8'h22, 8'hAE, 8'hE3};
        int c0;
`ifdef OLED_RX_CMD_DECODE_EN
        decode_en = 1'b1;
`else
        decode_en = 1'b0;
`endif
        foreach (argc_tbl[i]) argc_tbl[i] = -1;
        foreach (ops[i]) argc_tbl[ops[i]] = 1;
        argc_tbl[8'h15] = 2;  argc_tbl[8'h75] = 2;
        argc_tbl[8'h25] = 4;  argc_tbl[8'h21] = 7;  argc_tbl[8'h22] = 10;
        for (int i = 8'hA4; i <= 8'hA7; i++) argc_tbl[i] = 0;
        argc_tbl[8'hAE] = 0;  argc_tbl[8'hAF] = 0;  argc_tbl[8'hE3] = 0;

        // Reset state
        wait_cyc(3);
        @(negedge clk_in);
        check_reset_outputs("reset");
        wait_cyc(1);
        rst_n_in = 1'b1;
        ready_force = 1'b1;
        wait_cyc(6);

        // Single command byte and latency
        lat = -1;
        send_byte(8'hAE, 1'b0, 1'b0);
        drain();
        chk("latency", lat, SYNC_STAGES + 2);
        chk("single_data", last_data, 8'hAE);
        chk("single_dc", last_dc, 0);
        chk("single_idx", last_idx, 0);

        // Multi-argument commands
        send_byte(8'h15, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b1);
        send_byte(8'h5F, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) send_byte(8'(i * 23), 1'b0, (i % 3) == 0);
        drain();
        chk("multi_last_idx", last_idx, decode_en ? 10 : 0);
        chk("multi_last_is_arg", last_is_arg, decode_en ? 1 : 0);
        chk("multi_no_cmd_err", cmd_seen, 0);

        // Fragment then a full byte
        send_bits(8'hA5, 5);
        wait_cyc(HALF_SCLK);
        oled_cs_n_in = 1'b1;
        exp_frag++;
        wait_cyc(8);
        send_byte(8'hAF, 1'b0, 1'b0);
        drain();
        chk("frag_pulses", frag_seen, 1);
        chk("frag_next_data", last_data, 8'hAF);
        chk("frag_next_idx", last_idx, 0);

        // Protocol errors
        c0 = cmd_seen;
        send_byte(8'h81, 1'b0, 1'b0);
        send_byte(8'h37, 1'b1, 1'b0);
        send_byte(8'h40, 1'b0, 1'b0);
        send_byte(8'hAF, 1'b0, 1'b0);
        drain();
        chk("proto_cmd_err_pulses", cmd_seen - c0, decode_en ? 2 : 0);
        chk("proto_last_data", last_data, 8'hAF);
        chk("proto_last_is_arg", last_is_arg, 0);

        // Randomized command streams with random backpressure
        rnd_mode = 1'b1;
        for (int n = 0; n < 40; n++) begin
            int r = $urandom_range(0, 9);
            if (r < 7) begin
                logic [7:0] op = ops[$urandom_range(0, 25)];
                int na = argc_tbl[op];
                if ($urandom_range(0, 7) == 0 && na > 0) na = $urandom_range(0, na - 1);
                send_byte(op, 1'b0, $urandom_range(0, 1) == 1);
                for (int a = 0; a < na; a++)
                    send_byte(8'($urandom), 1'b0, $urandom_range(0, 1) == 1);
            end else if (r < 9) begin
                send_byte(8'($urandom), 1'b1, $urandom_range(0, 1) == 1);
            end else begin
                send_byte(8'($urandom), 1'b0, $urandom_range(0, 1) == 1);
            end
        end
        oled_cs_n_in = 1'b1;
        wait_cyc(6);
        rnd_mode = 1'b0;
        ready_force = 1'b1;
        drain();
        chk("rand_cmd_err_count", cmd_seen, exp_cmd);
        chk("rand_frag_count", frag_seen, exp_frag);
        chk("rand_overflow", overflow, exp_ovf);

        // Backpressure: FIFO_DEPTH+1 bytes with no consumer
        ready_force = 1'b0;
        wait_cyc(4);
        for (int i = 1; i <= FIFO_DEPTH + 1; i++) send_byte(8'(8'h11 * i), 1'b1, 1'b0);
        wait_cyc(8);
        chk("bp_overflow_model", overflow, exp_ovf);
        chk("bp_overflow", overflow, 1);
        chk("bp_valid", rx_valid, 1);
        chk("bp_head_data", rx_data, 8'h11);
        ready_force = 1'b1;
        drain();
        chk("bp_last_data", last_data, 8'h44);
        chk("bp_overflow_sticky", overflow, 1);
        chk("bp_empty_after_drain", rx_valid, 0);

        // Reset in the middle of a byte while arguments are pending
        send_byte(8'h15, 1'b0, 1'b0);
        drain();
        send_bits(8'h3C, 4);
        rst_n_in = 1'b0;
        q.delete();
        m_left = 0;
        exp_ovf = 1'b0;
        @(negedge clk_in);
        check_reset_outputs("midrst");
        wait_cyc(2);
        oled_cs_n_in = 1'b1;
        oled_clk_in = 1'b0;
        rst_n_in = 1'b1;
        wait_cyc(6);
        send_byte(8'hA4, 1'b0, 1'b0);
        drain();
        chk("midrst_next_data", last_data, 8'hA4);
        chk("midrst_next_idx", last_idx, 0);
        chk("midrst_next_is_arg", last_is_arg, 0);
        chk("midrst_overflow", overflow, 0);
        chk("final_cmd_err_count", cmd_seen, exp_cmd);
        chk("final_frag_count", frag_seen, exp_frag);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
